// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 definitions for the message packer (write
//                side) and the hash engine (read side): packer state
//                encoding, block width, the padding marker byte and the
//                initial hash values H(0).
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

    localparam int SHA256_BLOCK_W = 512;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    // Initial hash value H(0); consumed by the engine side of the FIFO.
    localparam logic [0:7][31:0] HA_INIT = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_PUSH      = 3'd2,
        ST_PAD       = 3'd3,
        ST_PUSH_LAST = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_tail_builder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_tail_builder
//  Description : Combinational builder for the block holding the final
//                message word. Keeps slots below idx, inserts the masked
//                final word at slot idx, places 0x80 at byte p = 4*idx+bytes,
//                zero-fills the rest and, when it fits (p <= 55), writes the
//                64-bit bit length into words 14/15.
//  Ports       : word_i         final message word (big-endian)
//                bytes_i        valid bytes in word_i, 0..4
//                idx_i          slot of word_i within the block
//                block_i        block assembled so far
//                len_i          total message length in bits
//                block_o        masked and padded block
//                needs_extra_o  length does not fit, a further block follows
//                pad_in_extra_o 0x80 marker belongs at byte 0 of that block
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_tail_builder
    import sha256_pkg::*;
(
    input  logic [31:0]               word_i,
    input  logic [2:0]                bytes_i,
    input  logic [3:0]                idx_i,
    input  logic [SHA256_BLOCK_W-1:0] block_i,
    input  logic [63:0]               len_i,
    output logic [SHA256_BLOCK_W-1:0] block_o,
    output logic                      needs_extra_o,
    output logic                      pad_in_extra_o
);

    logic [6:0] w_pad_pos;

    // Byte index of the 0x80 marker; 64 means it spills into the next block.
    assign w_pad_pos      = {1'b0, idx_i, 2'b00} + {4'b0000, bytes_i};
    assign needs_extra_o  = (w_pad_pos > 7'd55);
    assign pad_in_extra_o = (w_pad_pos == 7'd64);

    // Slots above idx may hold stale words from the previous block, so every
    // byte at or beyond the final word is rebuilt rather than inherited.
    always_comb begin
        block_o = '0;
        for (int j = 0; j < 64; j++) begin
            if (4'(j / 4) < idx_i) begin
                block_o[8*(63-j) +: 8] = block_i[8*(63-j) +: 8];
            end else if ((4'(j / 4) == idx_i) && (3'(j % 4) < bytes_i)) begin
                block_o[8*(63-j) +: 8] = word_i[8*(3-(j%4)) +: 8];
            end else if (7'(j) == w_pad_pos) begin
                block_o[8*(63-j) +: 8] = SHA256_PAD_BYTE;
            end
        end
        if (!needs_extra_o) begin
            block_o[63:0] = len_i;
        end
    end

endmodule : sha256_tail_builder
`default_nettype wire

// File: rtl/sha256_msg_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_packer
//  Description : Write side of the 512-bit SHA-256 block FIFO. Packs 32-bit
//                big-endian message words into blocks, appends the 0x80 /
//                zero / 64-bit length padding and writes each finished block
//                to the FIFO.
//  Ports       : clk_i, rstn_i (async, active-low)
//                start_i, abort_i            message control
//                in_valid_i/in_ready_o       word handshake
//                in_data_i, in_last_i, in_bytes_i
//                fifo_full_i, fifo_wr_en_o, fifo_wr_dat_o   block FIFO
//                busy_o, done_o, bit_len_o   status
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_msg_packer
    import sha256_pkg::*;
#(
    parameter bit BYTE_SWAP = 1'b0,
    parameter int LEN_W     = 64
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               in_data_i,
    input  logic                      in_last_i,
    input  logic [2:0]                in_bytes_i,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_en_o,
    output logic [SHA256_BLOCK_W-1:0] fifo_wr_dat_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [LEN_W-1:0]          bit_len_o
);

    state_t                    r_state;
    logic [SHA256_BLOCK_W-1:0] r_block;
    logic [3:0]                r_idx;
    logic [LEN_W-1:0]          r_bit_len;
    logic                      r_tail_pending;
    logic                      r_pad_in_extra;

    logic [31:0]               w_word;
    logic [2:0]                w_bytes;
    logic [LEN_W-1:0]          w_bit_len_next;
    logic [63:0]               w_len64_next;
    logic [63:0]               w_len64_cur;
    logic [SHA256_BLOCK_W-1:0] w_tail_block;
    logic [SHA256_BLOCK_W-1:0] w_pad_block;
    logic                      w_needs_extra;
    logic                      w_pad_in_extra;
    logic                      w_accept;
    logic                      w_in_push;

    generate
        if (BYTE_SWAP) begin : g_swap
            assign w_word = {in_data_i[7:0], in_data_i[15:8],
                             in_data_i[23:16], in_data_i[31:24]};
        end else begin : g_noswap
            assign w_word = in_data_i;
        end
    endgenerate

    // Counts above 4 are treated as a full word.
    assign w_bytes  = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
    assign w_accept = (r_state == ST_FILL) && in_valid_i && !abort_i;

    assign w_bit_len_next = r_bit_len +
        LEN_W'(in_last_i ? {w_bytes, 3'b000} : 6'd32);

    generate
        if (LEN_W >= 64) begin : g_len_trunc
            assign w_len64_next = w_bit_len_next[63:0];
            assign w_len64_cur  = r_bit_len[63:0];
        end else begin : g_len_ext
            assign w_len64_next = {{(64-LEN_W){1'b0}}, w_bit_len_next};
            assign w_len64_cur  = {{(64-LEN_W){1'b0}}, r_bit_len};
        end
    endgenerate

    sha256_tail_builder u_tail (
        .word_i         (w_word),
        .bytes_i        (w_bytes),
        .idx_i          (r_idx),
        .block_i        (r_block),
        .len_i          (w_len64_next),
        .block_o        (w_tail_block),
        .needs_extra_o  (w_needs_extra),
        .pad_in_extra_o (w_pad_in_extra)
    );

    // Extra block: optional marker at byte 0, zeros, length in words 14/15.
    assign w_pad_block = {(r_pad_in_extra ? SHA256_PAD_BYTE : 8'h00),
                          440'd0, w_len64_cur};

    // The strobe is a decode of registered state; it falls with the state
    // register on reset and is suppressed by a same-cycle abort.
    assign w_in_push     = (r_state == ST_PUSH) || (r_state == ST_PUSH_LAST);
    assign fifo_wr_en_o  = w_in_push && !fifo_full_i && !abort_i;
    assign fifo_wr_dat_o = r_block;
    assign in_ready_o    = (r_state == ST_FILL);
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
    assign bit_len_o     = r_bit_len;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state        <= ST_IDLE;
            r_block        <= '0;
            r_idx          <= 4'd0;
            r_bit_len      <= '0;
            r_tail_pending <= 1'b0;
            r_pad_in_extra <= 1'b0;
        end else if (abort_i && (r_state != ST_IDLE)) begin
            r_state        <= ST_IDLE;
            r_idx          <= 4'd0;
            r_tail_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state        <= ST_FILL;
                        r_block        <= '0;
                        r_idx          <= 4'd0;
                        r_bit_len      <= '0;
                        r_tail_pending <= 1'b0;
                        r_pad_in_extra <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_bit_len <= w_bit_len_next;
                        if (in_last_i) begin
                            r_block        <= w_tail_block;
                            r_idx          <= 4'd0;
                            r_tail_pending <= w_needs_extra;
                            r_pad_in_extra <= w_pad_in_extra;
                            r_state        <= w_needs_extra ? ST_PUSH
                                                            : ST_PUSH_LAST;
                        end else begin
                            r_block[32*(4'd15 - r_idx) +: 32] <= w_word;
                            if (r_idx == 4'd15) begin
                                r_idx   <= 4'd0;
                                r_state <= ST_PUSH;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (!fifo_full_i) begin
                        r_state <= r_tail_pending ? ST_PAD : ST_FILL;
                    end
                end
                ST_PAD: begin
                    r_block        <= w_pad_block;
                    r_tail_pending <= 1'b0;
                    r_state        <= ST_PUSH_LAST;
                end
                ST_PUSH_LAST: begin
                    if (!fifo_full_i) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : sha256_msg_packer
`default_nettype wire

// File: tb/tb_sha256_msg_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_packer
//  Description : Directed self-checking bench for sha256_msg_packer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_msg_packer;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [31:0]  in_data_i = '0;
    logic         in_last_i = 1'b0;
    logic [2:0]   in_bytes_i = '0;
    logic         fifo_full_i = 1'b0;
    logic         fifo_wr_en_o;
    logic [511:0] fifo_wr_dat_o;
    logic         busy_o;
    logic         done_o;
    logic [63:0]  bit_len_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [511:0] r_blks [$];
    int           r_ndone = 0;

    sha256_msg_packer #(.BYTE_SWAP(1'b0), .LEN_W(64)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .in_last_i     (in_last_i),
        .in_bytes_i    (in_bytes_i),
        .fifo_full_i   (fifo_full_i),
        .fifo_wr_en_o  (fifo_wr_en_o),
        .fifo_wr_dat_o (fifo_wr_dat_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .bit_len_o     (bit_len_o)
    );

    always #5 clk_i = ~clk_i;

    // Capture every FIFO write and done pulse seen at the active edge.
    always @(posedge clk_i) begin
        if (fifo_wr_en_o) r_blks.push_back(fifo_wr_dat_o);
        if (done_o) r_ndone++;
    end

    task automatic check_val(input string tag, input logic [511:0] act,
                             input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA0B0C0D0 ^ (32'(i) * 32'h01010101);
    endfunction

    function automatic logic [511:0] data_blk(input int base);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*(15-k) +: 32] = pat(base + k);
        return b;
    endfunction

    task automatic clear_log();
        r_blks.delete();
        r_ndone = 0;
    endtask

    task automatic start_msg();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last,
                             input logic [2:0] b);
        int t = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        in_bytes_i = b;
        while (!in_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 200) check_val("ready_timeout", 512'(in_ready_o), 512'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done_o && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        check_val(tag, 512'(done_o), 512'd1);
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rdy"},  512'(in_ready_o),   512'd0);
        check_val({tag, "_wr"},   512'(fifo_wr_en_o), 512'd0);
        check_val({tag, "_dat"},  fifo_wr_dat_o,      512'd0);
        check_val({tag, "_busy"}, 512'(busy_o),       512'd0);
        check_val({tag, "_done"}, 512'(done_o),       512'd0);
        check_val({tag, "_len"},  512'(bit_len_o),    512'd0);
    endtask

    initial begin
        logic [511:0] exp_b;
        logic         bad;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // 1: "abc"
        clear_log();
        start_msg();
        push_word(32'h61626300, 1'b1, 3'd3);
        wait_done("abc_done");
        check_val("abc_nwr", 512'(r_blks.size()), 512'd1);
        if (r_blks.size() >= 1)
            check_val("abc_blk", r_blks[0], {32'h61626380, 416'd0, 64'h18});
        check_val("abc_len", 512'(bit_len_o), 512'h18);
        check_val("abc_ndone", 512'(r_ndone), 512'd1);

        // 2: empty message
        clear_log();
        start_msg();
        push_word(32'hDEADBEEF, 1'b1, 3'd0);
        wait_done("empty_done");
        check_val("empty_nwr", 512'(r_blks.size()), 512'd1);
        if (r_blks.size() >= 1)
            check_val("empty_blk", r_blks[0], {32'h80000000, 480'd0});
        check_val("empty_len", 512'(bit_len_o), 512'd0);

        // 3: 56 bytes
        clear_log();
        start_msg();
        for (int i = 0; i < 14; i++) push_word(pat(i), i == 13, 3'd4);
        wait_done("b56_done");
        check_val("b56_nwr", 512'(r_blks.size()), 512'd2);
        exp_b = data_blk(0);
        exp_b[63:0] = {32'h80000000, 32'h0};
        if (r_blks.size() >= 2) begin
            check_val("b56_blk1", r_blks[0], exp_b);
            check_val("b56_blk2", r_blks[1], {480'd0, 32'h000001C0});
        end

        // 4a: 64 bytes
        clear_log();
        start_msg();
        for (int i = 0; i < 16; i++) push_word(pat(i), i == 15, 3'd4);
        wait_done("b64_done");
        check_val("b64_nwr", 512'(r_blks.size()), 512'd2);
        if (r_blks.size() >= 2) begin
            check_val("b64_blk1", r_blks[0], data_blk(0));
            check_val("b64_blk2", r_blks[1], {32'h80000000, 448'd0, 32'h200});
        end

        // 4b: 68 bytes (17 words)
        clear_log();
        start_msg();
        for (int i = 0; i < 17; i++) push_word(pat(i), i == 16, 3'd4);
        wait_done("b68_done");
        check_val("b68_len", 512'(bit_len_o), 512'h220);
        check_val("b68_nwr", 512'(r_blks.size()), 512'd2);
        if (r_blks.size() >= 2) begin
            check_val("b68_blk1", r_blks[0], data_blk(0));
            check_val("b68_blk2", r_blks[1],
                      {pat(16), 32'h80000000, 416'd0, 32'h220});
        end

        // 5: FIFO full held during PUSH
        clear_log();
        fifo_full_i = 1'b1;
        start_msg();
        for (int i = 0; i < 16; i++) push_word(pat(i), 1'b0, 3'd4);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (fifo_wr_en_o || in_ready_o || !busy_o || fifo_wr_dat_o !== data_blk(0))
                bad = 1'b1;
            @(negedge clk_i);
        end
        check_val("full_hold", 512'(bad), 512'd0);
        check_val("full_nwr", 512'(r_blks.size()), 512'd0);
        fifo_full_i = 1'b0;
        push_word(32'h0, 1'b1, 3'd0);
        wait_done("full_done");
        check_val("full_nwr2", 512'(r_blks.size()), 512'd2);
        if (r_blks.size() >= 2) begin
            check_val("full_blk1", r_blks[0], data_blk(0));
            check_val("full_blk2", r_blks[1], {32'h80000000, 448'd0, 32'h200});
        end

        // 6a: abort on the push cycle
        clear_log();
        fifo_full_i = 1'b1;
        start_msg();
        push_word(32'h61626300, 1'b1, 3'd3);
        @(negedge clk_i);
        fifo_full_i = 1'b0;
        abort_i = 1'b1;
        #1;
        check_val("abort_wr", 512'(fifo_wr_en_o), 512'd0);
        @(negedge clk_i);
        abort_i = 1'b0;
        check_val("abort_busy", 512'(busy_o), 512'd0);
        repeat (5) @(negedge clk_i);
        check_val("abort_nwr", 512'(r_blks.size()), 512'd0);
        check_val("abort_ndone", 512'(r_ndone), 512'd0);

        // 6b: async reset mid-FILL
        start_msg();
        push_word(pat(0), 1'b0, 3'd4);
        push_word(pat(1), 1'b0, 3'd4);
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sha256_msg_packer
`default_nettype wire
